// File: rtl/bitmask_spram_packer.sv
// Packs the thresholded 1-bit pixel stream into 16-bit SPRAM words, double-buffers frames
// across two banks and hands each finished bank to the system-clock reader by toggle.
module bitmask_spram_packer #(
   parameter int PIX_PER_FRAME = 76800,
   parameter int WORD_W        = 16,
   parameter int BANK_WORDS    = 4800,
   parameter int ADDR_W        = 14
) (
   input  logic              cam_pclk,
   input  logic              nreset,
   input  logic              pix_wr_en,
   input  logic [16:0]       pix_wr_addr,
   input  logic              pix_wr_data,
   input  logic              frame_done,
   input  logic              rd_release_toggle,
   output logic              spram_we,
   output logic [ADDR_W-1:0] spram_addr,
   output logic [WORD_W-1:0] spram_wdata,
   output logic [3:0]        spram_maskwren,
   output logic              frame_ready_toggle,
   output logic              ready_bank,
   output logic [7:0]        frame_count,
   output logic [7:0]        drop_count,
   output logic              addr_err
);

   typedef enum logic [1:0] {
      CAPTURE = 2'd0,
      FLUSH   = 2'd1,
      PUBLISH = 2'd2
   } state_t;

   localparam logic [16:0]       PIX_LIMIT  = 17'(PIX_PER_FRAME);
   localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(BANK_WORDS);

   function automatic logic [WORD_W-1:0] set_pixel(input logic [WORD_W-1:0] word,
                                                   input logic [3:0]        bit_idx,
                                                   input logic              val);
      logic [WORD_W-1:0] result;
      result          = word;
      result[bit_idx] = val;
      return result;
   endfunction

   function automatic logic [ADDR_W-1:0] word_addr(input logic bank, input logic [12:0] idx);
      logic [ADDR_W-1:0] offset;
      offset = ADDR_W'(idx);
      if (bank) begin
         return BANK1_BASE + offset;
      end else begin
         return offset;
      end
   endfunction

   state_t              state_r;
   state_t              state_nxt_s;
   logic [2:0]          sync_r;
   logic                release_edge_s;
   logic                busy_released_s;
   logic                pix_ok_s;
   logic                pix_bad_s;
   logic [12:0]         pix_idx_s;
   logic [3:0]          pix_bit_s;
   logic [WORD_W-1:0]   merge_base_s;

   logic                pending_valid_r;
   logic                pending_valid_nxt_s;
   logic [12:0]         pending_idx_r;
   logic [12:0]         pending_idx_nxt_s;
   logic [WORD_W-1:0]   pending_word_r;
   logic [WORD_W-1:0]   pending_word_nxt_s;
   logic                wr_bank_r;
   logic                wr_bank_nxt_s;
   logic                reader_busy_r;
   logic                reader_busy_nxt_s;

   logic                we_nxt_s;
   logic [ADDR_W-1:0]   waddr_nxt_s;
   logic [WORD_W-1:0]   wdata_nxt_s;
   logic                toggle_nxt_s;
   logic                ready_bank_nxt_s;
   logic [7:0]          frame_count_nxt_s;
   logic [7:0]          drop_count_nxt_s;
   logic                addr_err_nxt_s;

   assign release_edge_s  = sync_r[1] ^ sync_r[2];
   assign busy_released_s = reader_busy_r & ~release_edge_s;
   assign pix_idx_s       = pix_wr_addr[16:4];
   assign pix_bit_s       = pix_wr_addr[3:0];
   assign pix_ok_s        = pix_wr_en & (pix_wr_addr < PIX_LIMIT);
   assign pix_bad_s       = pix_wr_en & (pix_wr_addr >= PIX_LIMIT);
   // Pixels landing in the pending word merge into it; otherwise they start from a zeroed word.
   assign merge_base_s    = (pending_valid_r && (pending_idx_r == pix_idx_s)) ? pending_word_r
                                                                              : {WORD_W{1'b0}};

   // Frame sequencing state register.
   always_ff @(posedge cam_pclk or negedge nreset) begin
      if (!nreset) begin
         state_r <= CAPTURE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state, packing, write emission and bank hand-off decisions.
   always_comb begin
      state_nxt_s         = state_r;
      pending_valid_nxt_s = pending_valid_r;
      pending_idx_nxt_s   = pending_idx_r;
      pending_word_nxt_s  = pending_word_r;
      wr_bank_nxt_s       = wr_bank_r;
      reader_busy_nxt_s   = busy_released_s;
      we_nxt_s            = 1'b0;
      waddr_nxt_s         = {ADDR_W{1'b0}};
      wdata_nxt_s         = {WORD_W{1'b0}};
      toggle_nxt_s        = frame_ready_toggle;
      ready_bank_nxt_s    = ready_bank;
      frame_count_nxt_s   = frame_count;
      drop_count_nxt_s    = drop_count;
      addr_err_nxt_s      = addr_err;

      case (state_r)
         CAPTURE: begin
            if (pix_ok_s) begin
               if (pending_valid_r && (pending_idx_r != pix_idx_s)) begin
                  // Address skip: retire the old word; the new pixel stays pending even at bit 15
                  // because only one write can leave per cycle.
                  we_nxt_s            = 1'b1;
                  waddr_nxt_s         = word_addr(wr_bank_r, pending_idx_r);
                  wdata_nxt_s         = pending_word_r;
                  pending_valid_nxt_s = 1'b1;
                  pending_idx_nxt_s   = pix_idx_s;
                  pending_word_nxt_s  = set_pixel({WORD_W{1'b0}}, pix_bit_s, pix_wr_data);
               end else if (pix_bit_s == 4'd15) begin
                  we_nxt_s            = 1'b1;
                  waddr_nxt_s         = word_addr(wr_bank_r, pix_idx_s);
                  wdata_nxt_s         = set_pixel(merge_base_s, pix_bit_s, pix_wr_data);
                  pending_valid_nxt_s = 1'b0;
                  pending_word_nxt_s  = {WORD_W{1'b0}};
               end else begin
                  pending_valid_nxt_s = 1'b1;
                  pending_idx_nxt_s   = pix_idx_s;
                  pending_word_nxt_s  = set_pixel(merge_base_s, pix_bit_s, pix_wr_data);
               end
            end else if (pix_bad_s) begin
               addr_err_nxt_s = 1'b1;
            end else begin
               addr_err_nxt_s = addr_err;
            end
            if (frame_done) begin
               state_nxt_s = FLUSH;
            end else begin
               state_nxt_s = CAPTURE;
            end
         end
         FLUSH: begin
            if (pending_valid_r) begin
               we_nxt_s            = 1'b1;
               waddr_nxt_s         = word_addr(wr_bank_r, pending_idx_r);
               wdata_nxt_s         = pending_word_r;
               pending_valid_nxt_s = 1'b0;
               pending_word_nxt_s  = {WORD_W{1'b0}};
            end else begin
               we_nxt_s = 1'b0;
            end
            state_nxt_s = PUBLISH;
         end
         PUBLISH: begin
            // A release arriving this same cycle has already been folded into busy_released_s.
            if (!busy_released_s) begin
               ready_bank_nxt_s  = wr_bank_r;
               toggle_nxt_s      = ~frame_ready_toggle;
               reader_busy_nxt_s = 1'b1;
               wr_bank_nxt_s     = ~wr_bank_r;
               frame_count_nxt_s = frame_count + 8'd1;
            end else if (drop_count != 8'hFF) begin
               drop_count_nxt_s = drop_count + 8'd1;
            end else begin
               drop_count_nxt_s = drop_count;
            end
            state_nxt_s = CAPTURE;
         end
         default: begin
            state_nxt_s = CAPTURE;
         end
      endcase
   end

   // Datapath, bank bookkeeping, release synchroniser and registered outputs.
   always_ff @(posedge cam_pclk or negedge nreset) begin
      if (!nreset) begin
         sync_r             <= 3'b000;
         pending_valid_r    <= 1'b0;
         pending_idx_r      <= 13'd0;
         pending_word_r     <= {WORD_W{1'b0}};
         wr_bank_r          <= 1'b0;
         reader_busy_r      <= 1'b0;
         spram_we           <= 1'b0;
         spram_addr         <= {ADDR_W{1'b0}};
         spram_wdata        <= {WORD_W{1'b0}};
         spram_maskwren     <= 4'h0;
         frame_ready_toggle <= 1'b0;
         ready_bank         <= 1'b0;
         frame_count        <= 8'd0;
         drop_count         <= 8'd0;
         addr_err           <= 1'b0;
      end else begin
         sync_r             <= {sync_r[1:0], rd_release_toggle};
         pending_valid_r    <= pending_valid_nxt_s;
         pending_idx_r      <= pending_idx_nxt_s;
         pending_word_r     <= pending_word_nxt_s;
         wr_bank_r          <= wr_bank_nxt_s;
         reader_busy_r      <= reader_busy_nxt_s;
         spram_we           <= we_nxt_s;
         spram_addr         <= waddr_nxt_s;
         spram_wdata        <= wdata_nxt_s;
         spram_maskwren     <= we_nxt_s ? 4'hF : 4'h0;
         frame_ready_toggle <= toggle_nxt_s;
         ready_bank         <= ready_bank_nxt_s;
         frame_count        <= frame_count_nxt_s;
         drop_count         <= drop_count_nxt_s;
         addr_err           <= addr_err_nxt_s;
      end
   end

endmodule
